// File: rtl/qbus_master_pkg.sv
// Shared definitions for the Q-bus master: FSM state encoding, cycle kinds, default reply timeout.
// S_RMW_WAIT exists only when QBUS_RMW_EN is defined.
package qbus_master_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_DATA     = 3'd2,
    S_END      = 3'd3,
`ifdef QBUS_RMW_EN
    S_RMW_WAIT = 3'd5,
`endif
    S_ERR      = 3'd4
  } state_t;

  typedef enum logic {
    K_READ  = 1'b0,
    K_WRITE = 1'b1
  } kind_t;

  localparam int TMO_CYC_DEF = 63;

endpackage

// File: rtl/qbus_timeout.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
module qbus_timeout #(
  parameter int TMO_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [TMO_W-1:0] load_val,
  output logic             zero
);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && (cnt != '0))
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/qbus_master.sv
// Q-bus DATI/DATO cycle sequencer with reply timeout and bus-error reporting.
// Optional QBUS_RMW_EN adds rmw_i and a DATIO (read-modify-write) cycle with SYNC held throughout.
module qbus_master
  import qbus_master_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TMO_W   = 6,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              rd_i,
  input  logic              wr_i,
  input  logic              byte_i,
`ifdef QBUS_RMW_EN
  input  logic              rmw_i,
`endif
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              done_o,
  output logic              err_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              sync_o,
  output logic              din_o,
  output logic              dout_o,
  output logic              wtbt_o,
  output logic              bsy_o,
  input  logic              rply_i
);

  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO_CYC);

  state_t state;
  kind_t  kind;
  logic   byte_q;
  logic   rmw_q;
  logic   tmo_load, tmo_dec, tmo_zero;

  qbus_timeout #(.TMO_W(TMO_W)) u_tmo (
    .clk      (clk),
    .reset    (reset),
    .load     (tmo_load),
    .dec      (tmo_dec),
    .load_val (TMO_LOAD),
    .zero     (tmo_zero)
  );

  // The timeout window restarts at every phase boundary: address, reply assert, and RMW write phase.
  always_comb begin
    tmo_load = 1'b0;
    tmo_dec  = 1'b0;
    if (ce) begin
      case (state)
        S_ADDR: tmo_load = 1'b1;
        S_DATA: begin
          if (rply_i) tmo_load = 1'b1;
          else        tmo_dec  = 1'b1;
        end
        S_END: if (rply_i) tmo_dec = 1'b1;
`ifdef QBUS_RMW_EN
        S_RMW_WAIT: if (wr_i) tmo_load = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  assign bsy_o = sync_o;

`ifndef QBUS_RMW_EN
  assign rmw_q = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      kind    <= K_READ;
      byte_q  <= 1'b0;
      rdata_o <= '0;
      addr_o  <= '0;
      data_o  <= '0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
      busy_o  <= 1'b0;
      sync_o  <= 1'b0;
      din_o   <= 1'b0;
      dout_o  <= 1'b0;
      wtbt_o  <= 1'b0;
`ifdef QBUS_RMW_EN
      rmw_q   <= 1'b0;
`endif
    end else if (ce) begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rd_i || wr_i) begin
            addr_o <= addr_i;
            byte_q <= byte_i;
            kind   <= rd_i ? K_READ : K_WRITE;
            if (!rd_i) data_o <= wdata_i;
`ifdef QBUS_RMW_EN
            rmw_q  <= rd_i && rmw_i;
`endif
            sync_o <= 1'b1;
            busy_o <= 1'b1;
            state  <= S_ADDR;
          end
        end
        S_ADDR: begin
          din_o  <= (kind == K_READ);
          dout_o <= (kind == K_WRITE);
          wtbt_o <= byte_q;
          state  <= S_DATA;
        end
        S_DATA: begin
          if (rply_i) begin
            if (kind == K_READ) rdata_o <= data_i;
            din_o  <= 1'b0;
            dout_o <= 1'b0;
            wtbt_o <= 1'b0;
            sync_o <= rmw_q;
            state  <= S_END;
          end else if (tmo_zero) begin
            din_o  <= 1'b0;
            dout_o <= 1'b0;
            wtbt_o <= 1'b0;
            sync_o <= 1'b0;
            err_o  <= 1'b1;
            state  <= S_ERR;
          end
        end
        S_END: begin
          if (!rply_i) begin
            done_o <= 1'b1;
`ifdef QBUS_RMW_EN
            if (rmw_q) begin
              state <= S_RMW_WAIT;
            end else begin
              busy_o <= 1'b0;
              state  <= S_IDLE;
            end
`else
            busy_o <= 1'b0;
            state  <= S_IDLE;
`endif
          end else if (tmo_zero) begin
            sync_o <= 1'b0;
            err_o  <= 1'b1;
            state  <= S_ERR;
          end
        end
        S_ERR: begin
          sync_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
`ifdef QBUS_RMW_EN
        // SYNC stays asserted while the requester prepares the modified word.
        S_RMW_WAIT: begin
          if (wr_i) begin
            data_o <= wdata_i;
            kind   <= K_WRITE;
            rmw_q  <= 1'b0;
            dout_o <= 1'b1;
            wtbt_o <= byte_q;
            state  <= S_DATA;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qbus_master.sv
// Self-checking bench for qbus_master: slave model, scoreboard of expected completions, scenario tasks.
module tb_qbus_master;

  typedef struct packed {
    logic [1:0]  kind;   // 0 read done, 1 write done, 2 bus error
    logic [15:0] val;
    logic        wtbt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, rd_i, wr_i, byte_i, rply_i;
  logic ce = 1'b1;
`ifdef QBUS_RMW_EN
  logic rmw_i;
`endif
  logic [15:0] addr_i, wdata_i, data_i, rdata_o, addr_o, data_o;
  logic done_o, err_o, busy_o, sync_o, din_o, dout_o, wtbt_o, bsy_o;

  int checks = 0;
  int passed = 0;
  exp_t sb[$];

  logic        slave_en = 1'b0;
  int          slave_wait = 0;
  logic [15:0] slave_rdata = 16'h0;
  int          scnt = 0;
  logic [15:0] wr_seen = 16'h0;
  logic        wtbt_seen = 1'b0;
  logic        ce_toggle = 1'b0;
  logic        done_q = 1'b0, err_q = 1'b0;

  qbus_master dut (
    .clk(clk), .reset(reset), .ce(ce), .rd_i(rd_i), .wr_i(wr_i), .byte_i(byte_i),
`ifdef QBUS_RMW_EN
    .rmw_i(rmw_i),
`endif
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .done_o(done_o), .err_o(err_o),
    .busy_o(busy_o), .addr_o(addr_o), .data_o(data_o), .data_i(data_i), .sync_o(sync_o),
    .din_o(din_o), .dout_o(dout_o), .wtbt_o(wtbt_o), .bsy_o(bsy_o), .rply_i(rply_i)
  );

  // Slave: counts ce-qualified strobe cycles, replies after slave_wait of them.
  always @(posedge clk) begin
    if (!(din_o || dout_o)) scnt <= 0;
    else if (ce) scnt <= scnt + 1;
    if (ce && dout_o && rply_i) begin
      wr_seen   <= data_o;
      wtbt_seen <= wtbt_o;
    end
  end

  always @(negedge clk) begin
    rply_i = slave_en && (din_o || dout_o) && (scnt >= slave_wait);
    data_i = slave_rdata;
    if (ce_toggle) ce = ~ce;
    else ce = 1'b1;
  end

  // Scoreboard monitor: every done_o/err_o rising edge pops one expected completion.
  always @(negedge clk) begin
    exp_t e;
    if (done_o && !done_q) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_done: done_o with nothing expected, rdata_o=%h", rdata_o);
      end else begin
        e = sb.pop_front();
        if (e.kind == 2'd0 && rdata_o === e.val) passed++;
        else if (e.kind == 2'd1 && wr_seen === e.val && wtbt_seen === e.wtbt) passed++;
        else $display("FAIL sb_done: kind=%0d rdata_o=%h wr_seen=%h wtbt=%b, required val=%h wtbt=%b",
                      e.kind, rdata_o, wr_seen, wtbt_seen, e.val, e.wtbt);
      end
    end
    if (err_o && !err_q) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_err: err_o with nothing expected");
      end else begin
        e = sb.pop_front();
        if (e.kind == 2'd2 && rdata_o === e.val && {sync_o, din_o, dout_o, wtbt_o} === 4'b0) passed++;
        else $display("FAIL sb_err: kind=%0d rdata_o=%h strobes=%b, required kind=2 rdata=%h strobes=0000",
                      e.kind, rdata_o, {sync_o, din_o, dout_o, wtbt_o}, e.val);
      end
    end
    done_q = done_o;
    err_q  = err_o;
  end

  task automatic test_reset();
    reset = 1'b1; rd_i = 1'b0; wr_i = 1'b0; byte_i = 1'b0;
    addr_i = 16'h0; wdata_i = 16'h0;
`ifdef QBUS_RMW_EN
    rmw_i = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checks++;
    if ({sync_o, din_o, dout_o, wtbt_o, bsy_o, busy_o, done_o, err_o} !== 8'h0)
      $display("FAIL reset_ctl: got %b required 00000000",
               {sync_o, din_o, dout_o, wtbt_o, bsy_o, busy_o, done_o, err_o});
    else passed++;
    checks++;
    if ({rdata_o, addr_o, data_o} !== 48'h0)
      $display("FAIL reset_data: got %h required 0", {rdata_o, addr_o, data_o});
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_read();
    int n = 0, syncs = 0, dins = 0, badaddr = 0;
    slave_en = 1'b1; slave_wait = 1; slave_rdata = 16'o012345;
    sb.push_back('{2'd0, 16'o012345, 1'b0});
    rd_i = 1'b1; byte_i = 1'b0; addr_i = 16'o100000;
    do begin
      @(negedge clk); n++;
      if (busy_o) rd_i = 1'b0;
      if (sync_o) syncs++;
      if (din_o) dins++;
      if (sync_o && addr_o !== 16'o100000) badaddr++;
    end while (busy_o && n < 40);
    checks++; if (syncs == 3) passed++; else $display("FAIL read_sync_len: got %0d required 3", syncs);
    checks++; if (dins == 2) passed++; else $display("FAIL read_din_len: got %0d required 2", dins);
    checks++; if (badaddr == 0) passed++; else $display("FAIL read_addr: %0d bad cycles required 0", badaddr);
    checks++; if (n == 5 && done_o === 1'b1) passed++;
    else $display("FAIL read_latency: done after %0d cycles (done_o=%b) required 5", n, done_o);
  endtask

  task automatic test_byte_write();
    int n = 0, douts = 0, wbad = 0, dbad = 0;
    logic seen = 1'b0;
    slave_en = 1'b1; slave_wait = 0;
    sb.push_back('{2'd1, 16'h00A5, 1'b1});
    wr_i = 1'b1; byte_i = 1'b1; addr_i = 16'o177716; wdata_i = 16'h00A5;
    do begin
      @(negedge clk); n++;
      if (busy_o) begin seen = 1'b1; wr_i = 1'b0; end
      if (dout_o) douts++;
      if ((dout_o && !wtbt_o) || (!sync_o && wtbt_o) || din_o) wbad++;
      if (busy_o && (data_o !== 16'h00A5 || addr_o !== 16'o177716)) dbad++;
    end while (!(seen && !busy_o) && n < 40);
    byte_i = 1'b0;
    checks++; if (douts == 1) passed++; else $display("FAIL wr_dout_len: got %0d required 1", douts);
    checks++; if (wbad == 0) passed++; else $display("FAIL wr_wtbt: %0d bad cycles required 0", wbad);
    checks++; if (dbad == 0) passed++; else $display("FAIL wr_data_hold: %0d bad cycles required 0", dbad);
    checks++; if (n == 4) passed++; else $display("FAIL wr_latency: got %0d required 4", n);
  endtask

  task automatic test_timeout();
    int n = 0, t_din = -1, t_err = -1, dins = 0;
    logic seen = 1'b0;
    slave_en = 1'b0;
    sb.push_back('{2'd2, 16'o012345, 1'b0});
    rd_i = 1'b1; addr_i = 16'o000200;
    do begin
      @(negedge clk); n++;
      if (busy_o) begin seen = 1'b1; rd_i = 1'b0; end
      if (din_o) begin dins++; if (t_din < 0) t_din = n; end
      if (err_o && t_err < 0) t_err = n;
    end while (!(seen && !busy_o) && n < 200);
    checks++; if (t_din > 0 && t_err - t_din == 64) passed++;
    else $display("FAIL tmo_delay: err at %0d after S_DATA entry, required 64", t_err - t_din);
    checks++; if (dins == 64) passed++; else $display("FAIL tmo_din_len: got %0d required 64", dins);
    slave_en = 1'b1;
  endtask

  task automatic test_both_ce();
    int n = 0, t_sync = -1, t_done = -1, syncs = 0, dins = 0, douts = 0;
    logic seen = 1'b0;
    slave_en = 1'b1; slave_wait = 1; slave_rdata = 16'h5A5A;
    sb.push_back('{2'd0, 16'h5A5A, 1'b0});
    ce_toggle = 1'b1;
    rd_i = 1'b1; wr_i = 1'b1; addr_i = 16'o000100; wdata_i = 16'hFFFF;
    do begin
      @(negedge clk); n++;
      if (busy_o) begin seen = 1'b1; rd_i = 1'b0; wr_i = 1'b0; end
      if (sync_o) begin syncs++; if (t_sync < 0) t_sync = n; end
      if (din_o) dins++;
      if (dout_o) douts++;
      if (done_o && t_done < 0) t_done = n;
    end while (!(seen && !busy_o) && n < 80);
    ce_toggle = 1'b0;
    checks++; if (t_sync > 0 && t_done - t_sync == 8) passed++;
    else $display("FAIL ce_latency: sync-to-done %0d required 8", t_done - t_sync);
    checks++; if (syncs == 6 && dins == 4) passed++;
    else $display("FAIL ce_stretch: sync=%0d din=%0d required 6 and 4", syncs, dins);
    checks++; if (douts == 0) passed++; else $display("FAIL rdwr_no_write: dout cycles %0d required 0", douts);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    logic seen = 1'b0;
    slave_en = 1'b0;
    rd_i = 1'b1; addr_i = 16'o000300;
    do begin
      @(negedge clk); n++;
      if (busy_o) rd_i = 1'b0;
    end while (!din_o && n < 20);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({sync_o, din_o, dout_o, busy_o, done_o, err_o} !== 6'b0 || {rdata_o, addr_o} !== 32'h0)
      $display("FAIL reset_mid: ctl=%b rdata=%h addr=%h required all 0",
               {sync_o, din_o, dout_o, busy_o, done_o, err_o}, rdata_o, addr_o);
    else passed++;
    slave_en = 1'b1; slave_wait = 0; slave_rdata = 16'h1234;
    sb.push_back('{2'd0, 16'h1234, 1'b0});
    rd_i = 1'b1; addr_i = 16'o000302; n = 0;
    do begin
      @(negedge clk); n++;
      if (busy_o) begin seen = 1'b1; rd_i = 1'b0; end
    end while (!(seen && !busy_o) && n < 40);
    checks++; if (n == 4) passed++; else $display("FAIL reset_recover: latency %0d required 4", n);
  endtask

  task automatic test_back_to_back();
    int n = 0, dcount = 0;
    logic after_done = 1'b0, got_busy = 1'b0;
    slave_en = 1'b1; slave_wait = 0; slave_rdata = 16'h0F0F;
    sb.push_back('{2'd0, 16'h0F0F, 1'b0});
    sb.push_back('{2'd0, 16'h0F0F, 1'b0});
    rd_i = 1'b1; addr_i = 16'o000500;
    do begin
      @(negedge clk); n++;
      if (after_done) begin got_busy = busy_o; after_done = 1'b0; rd_i = 1'b0; end
      if (done_o) begin dcount++; if (dcount == 1) after_done = 1'b1; end
    end while (dcount < 2 && n < 40);
    rd_i = 1'b0;
    checks++; if (got_busy === 1'b1) passed++; else $display("FAIL b2b_accept: busy_o=%b required 1", got_busy);
    checks++; if (dcount == 2) passed++; else $display("FAIL b2b_count: got %0d required 2", dcount);
  endtask

`ifdef QBUS_RMW_EN
  task automatic test_rmw();
    int n = 0, dcount = 0, drop = 0, wait_cnt = -1;
    logic seen = 1'b0, seen_sync = 1'b0, seen_dout = 1'b0;
    slave_en = 1'b1; slave_wait = 0; slave_rdata = 16'o000777;
    sb.push_back('{2'd0, 16'o000777, 1'b0});
    sb.push_back('{2'd1, 16'o001000, 1'b0});
    rd_i = 1'b1; rmw_i = 1'b1; byte_i = 1'b0; addr_i = 16'o000400;
    do begin
      @(negedge clk); n++;
      if (busy_o) begin seen = 1'b1; rd_i = 1'b0; rmw_i = 1'b0; end
      if (sync_o) seen_sync = 1'b1;
      if (dout_o) begin seen_dout = 1'b1; wr_i = 1'b0; end
      if (seen_sync && !seen_dout && !sync_o) drop++;
      if (done_o) begin dcount++; if (dcount == 1) wait_cnt = 5; end
      if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0) begin wr_i = 1'b1; wdata_i = 16'o001000; end
      end
    end while (!(seen && !busy_o) && n < 100);
    checks++; if (drop == 0) passed++; else $display("FAIL rmw_sync_held: dropped %0d cycles required 0", drop);
    checks++; if (dcount == 2) passed++; else $display("FAIL rmw_done_count: got %0d required 2", dcount);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read();
    test_byte_write();
    test_timeout();
    test_both_ce();
    test_reset_mid();
    test_back_to_back();
`ifdef QBUS_RMW_EN
    test_rmw();
`endif
    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL sb_drain: %0d completions missing, required 0", sb.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
